// File: rtl/head_pkg.sv
// Shared constants and types for the head tensor engine.
package head_pkg;

   localparam int INSTR_W = 16;
   localparam int WORD_W  = 32;
   localparam int DIM     = 4;
   localparam int DEPTH   = DIM * DIM;

   localparam logic [7:0] OP_HALT      = 8'h00;
   localparam logic [7:0] OP_RELU      = 8'h01;
   localparam logic [7:0] OP_NEG       = 8'h02;
   localparam logic [7:0] OP_ABS       = 8'h03;
   localparam logic [7:0] OP_SCALE     = 8'h04;
   localparam logic [7:0] OP_TRANSPOSE = 8'h08;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2
   } state_t;

endpackage

// File: rtl/head_if.sv
// Flat parallel memory bus: every word readable and writable in one cycle.
interface head_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
);
   logic [WIDTH*DEPTH-1:0] rd_data;
   logic [WIDTH*DEPTH-1:0] wr_data;
   logic                   we;

   modport master (input rd_data, output wr_data, output we);
   modport slave  (output rd_data, input wr_data, input we);
endinterface

// File: rtl/head_regfile.sv
// Register file with all words exposed on a flat read bus and a write-all port.
module head_regfile #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input logic  clk,
   head_if.slave bus
);

   // Storage is deliberately not reset so externally loaded contents survive reset.
   logic [WIDTH-1:0] mem [0:DEPTH-1];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rd
      assign bus.rd_data[gi*WIDTH +: WIDTH] = mem[gi];
   end

   // Write every word at once when enabled.
   always_ff @(posedge clk) begin
      if (bus.we) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= bus.wr_data[i*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/head.sv
// Instruction-driven 4x4 float weight engine: fetch/exec/halt sequencer.
module head
   import head_pkg::*;
(
   input logic clk,
   input logic rst
);

   head_if #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) instr_bus ();
   head_if #(.WIDTH(WORD_W),  .DEPTH(DEPTH)) weight_bus ();

   head_regfile #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) instrMem (
      .clk (clk),
      .bus (instr_bus)
   );

   head_regfile #(.WIDTH(WORD_W), .DEPTH(DEPTH)) weightMem (
      .clk (clk),
      .bus (weight_bus)
   );

   // Instruction memory is read-only from the core's point of view.
   assign instr_bus.we      = 1'b0;
   assign instr_bus.wr_data = '0;

   state_t              state;
   state_t              state_next;
   logic [4:0]          pc;
   logic [INSTR_W-1:0]  ir;
   logic                halted;
   logic [7:0]          opcode;
   logic [3:0]          arg;
   logic                unused_ir_bits;

   assign opcode         = ir[7:0];
   assign arg            = ir[11:8];
   assign unused_ir_bits = ^ir[15:12];

   // Sign / exponent operation applied independently to one weight.
   function automatic logic [WORD_W-1:0] elem_op(input logic [WORD_W-1:0] w,
                                                 input logic [7:0] op,
                                                 input logic [3:0] a);
      logic [WORD_W-1:0] r;
      logic signed [9:0] ne;
      r  = w;
      ne = $signed({2'b00, w[30:23]}) + $signed({{6{a[3]}}, a});
      case (op)
         OP_RELU:  if (w[31]) r = '0;
         OP_NEG:   r[31] = ~w[31];
         OP_ABS:   r[31] = 1'b0;
         OP_SCALE: begin
            // Zero/denormal and inf/NaN encodings pass through untouched.
            if (w[30:23] != 8'h00 && w[30:23] != 8'hFF) begin
               if (ne >= 10'sd255)
                  r = {w[31], 8'hFF, 23'h0};
               else if (ne <= 10'sd0)
                  r = {w[31], 31'h0};
               else
                  r = {w[31], ne[7:0], w[22:0]};
            end
         end
         default: ;
      endcase
      return r;
   endfunction

   logic [WORD_W*DEPTH-1:0] op_words;
   logic [WORD_W*DEPTH-1:0] tr_words;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elem
      localparam int R = gi / DIM;
      localparam int C = gi % DIM;
      assign op_words[gi*WORD_W +: WORD_W] =
         elem_op(weight_bus.rd_data[gi*WORD_W +: WORD_W], opcode, arg);
      // Transpose reads only the pre-instruction contents.
      assign tr_words[gi*WORD_W +: WORD_W] =
         weight_bus.rd_data[(C*DIM + R)*WORD_W +: WORD_W];
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= S_FETCH;
         halted <= 1'b0;
      end else begin
         state  <= state_next;
         halted <= (state_next == S_HALT);
      end
   end

   // Program counter and instruction register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc <= '0;
         ir <= '0;
      end else begin
         if (state == S_FETCH)
            ir <= instr_bus.rd_data[{pc[3:0], 4'b0000} +: INSTR_W];
         if (state == S_EXEC)
            pc <= pc + 5'd1;
      end
   end

   // Next-state decode: halt on HALT opcode or after the last slot.
   always_comb begin
      state_next = state;
      case (state)
         S_FETCH: state_next = S_EXEC;
         S_EXEC:  state_next = (opcode == OP_HALT || pc == 5'd15) ? S_HALT : S_FETCH;
         S_HALT:  state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
   end

   // Weight write during EXEC; a reset on the same edge suppresses it.
   always_comb begin
      weight_bus.we      = 1'b0;
      weight_bus.wr_data = op_words;
      if (state == S_EXEC && rst) begin
         weight_bus.we = 1'b1;
         if (opcode == OP_TRANSPOSE)
            weight_bus.wr_data = tr_words;
      end
   end

endmodule

// File: tb/tb_head.sv
// Randomized and directed checks of head against a matrix-level reference model.
module tb_head;
   import head_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   head dut (
      .clk (clk),
      .rst (rst)
   );

   // Probe bus mirroring the weight memory for observation.
   head_if #(.WIDTH(WORD_W), .DEPTH(DEPTH)) probe ();
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_probe
      assign probe.rd_data[gi*WORD_W +: WORD_W] = dut.weightMem.mem[gi];
   end
   assign probe.we      = 1'b0;
   assign probe.wr_data = '0;

   int checks = 0;
   int errors = 0;

   logic [15:0] prog   [16];
   logic [31:0] wts    [16];
   logic [31:0] model  [16];
   int          exp_exec;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] float_of_int(input int n);
      int k;
      logic [31:0] m;
      if (n == 0) return 32'h0;
      k = 0;
      for (int b = 0; b < 31; b++) if (((n >> b) & 1) == 1) k = b;
      m = 32'(n) << (23 - k);
      return {1'b0, 8'(127 + k), m[22:0]};
   endfunction

   function automatic logic [31:0] scale_ref(input logic [31:0] w, input int a);
      int e;
      int ne;
      e = int'(w[30:23]);
      if (e == 0 || e == 255) return w;
      ne = e + a;
      if (ne >= 255) return {w[31], 31'h7F800000};
      if (ne <= 0)   return {w[31], 31'h0};
      return {w[31], 8'(ne), w[22:0]};
   endfunction

   // Execute one instruction on the whole model matrix.
   task automatic model_step(input logic [15:0] ins);
      logic [31:0] old [16];
      logic signed [3:0] sa;
      int a;
      sa = ins[11:8];
      a  = int'(sa);
      old = model;
      case (ins[7:0])
         8'h01: for (int i = 0; i < 16; i++) if (old[i][31]) model[i] = 32'h0;
         8'h02: for (int i = 0; i < 16; i++) model[i] = old[i] ^ 32'h80000000;
         8'h03: for (int i = 0; i < 16; i++) model[i] = old[i] & 32'h7FFFFFFF;
         8'h04: for (int i = 0; i < 16; i++) model[i] = scale_ref(old[i], a);
         8'h08: for (int r = 0; r < 4; r++)
                   for (int c = 0; c < 4; c++) model[r*4+c] = old[c*4+r];
         default: ;
      endcase
   endtask

   task automatic model_run();
      model = wts;
      exp_exec = 0;
      for (int p = 0; p < 16; p++) begin
         model_step(prog[p]);
         exp_exec++;
         if (prog[p][7:0] == 8'h00 || p == 15) break;
      end
   endtask

   // Hold reset, load both memories, then release.
   task automatic load_and_release(input string tag);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         dut.instrMem.mem[i]  = prog[i];
         dut.weightMem.mem[i] = wts[i];
      end
      check({tag, " rst_pc"},     32'(dut.pc), 32'h0);
      check({tag, " rst_ir"},     32'(dut.ir), 32'h0);
      check({tag, " rst_halted"}, 32'(dut.halted), 32'h0);
      check({tag, " rst_state"},  32'(dut.state), 32'(S_FETCH));
      rst = 1'b1;
   endtask

   task automatic check_weights(input string tag);
      for (int i = 0; i < 16; i++)
         check($sformatf("%s w%0d", tag, i), probe.rd_data[i*32 +: 32], model[i]);
   endtask

   task automatic run_test(input string tag);
      int cycles;
      model_run();
      load_and_release(tag);
      cycles = 0;
      while (!dut.halted && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      check({tag, " cycles"}, 32'(cycles), 32'(2 * exp_exec));
      check({tag, " halted"}, 32'(dut.halted), 32'h1);
      check({tag, " pc"},     32'(dut.pc), 32'(exp_exec));
      check_weights(tag);
      $display("txn %s: executed=%0d cycles=%0d pc=%0d", tag, exp_exec, cycles, dut.pc);
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 7))
         0: return 32'h00000000;
         1: return 32'h7FC00000;
         2: return 32'h7F000000;
         3: return 32'h00800000;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [15:0] rand_instr();
      logic [7:0] op;
      case ($urandom_range(0, 9))
         0: op = 8'h01;
         1: op = 8'h02;
         2: op = 8'h03;
         3, 4, 5: op = 8'h04;
         6: op = 8'h08;
         7: op = 8'($urandom_range(0, 255));
         8: op = 8'h04;
         default: op = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h02;
      endcase
      return {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), op};
   endfunction

   initial begin
      int cyc;

      // Chain of sign ops, transpose and x4 scale on all-ones.
      for (int i = 0; i < 16; i++) begin wts[i] = 32'h3F800000; prog[i] = 16'h0000; end
      prog[0] = 16'h0001; prog[1] = 16'h0002; prog[2] = 16'h0003;
      prog[3] = 16'h0008; prog[4] = 16'h0204;
      run_test("chain");
      check("chain literal w5", probe.rd_data[5*32 +: 32], 32'h40800000);

      // Transpose of 0..15.
      for (int i = 0; i < 16; i++) begin wts[i] = float_of_int(i); prog[i] = 16'h0000; end
      prog[0] = 16'h0008;
      run_test("transpose");
      check("transpose literal w1", probe.rd_data[1*32 +: 32], 32'h40800000);
      check("transpose literal w4", probe.rd_data[4*32 +: 32], 32'h3F800000);
      prog[1] = 16'h0008;
      run_test("transpose2");

      // RELU and NEG on alternating signs.
      for (int i = 0; i < 16; i++) begin
         wts[i] = (i % 2 == 0) ? 32'h40000000 : 32'hC0000000;
         prog[i] = 16'h0000;
      end
      prog[0] = 16'h0001;
      run_test("relu");
      check("relu literal w1", probe.rd_data[1*32 +: 32], 32'h00000000);
      prog[0] = 16'h0002;
      run_test("neg");
      check("neg literal w0", probe.rd_data[0*32 +: 32], 32'hC0000000);

      // SCALE boundaries.
      for (int i = 0; i < 16; i++) begin wts[i] = rand_word(); prog[i] = 16'h0000; end
      wts[0] = 32'h7F000000; wts[1] = 32'h00800000; wts[2] = 32'h00000000; wts[3] = 32'h7FC00000;
      prog[0] = 16'h0104;
      run_test("scale_up");
      check("scale_up literal w0", probe.rd_data[0*32 +: 32], 32'h7F800000);
      prog[0] = 16'h0F04;
      run_test("scale_dn");
      check("scale_dn literal w1", probe.rd_data[1*32 +: 32], 32'h00000000);
      check("scale_dn literal w3", probe.rd_data[3*32 +: 32], 32'h7FC00000);

      // Early HALT.
      for (int i = 0; i < 16; i++) begin wts[i] = rand_word(); prog[i] = 16'h0002; end
      prog[1] = 16'h0000;
      run_test("halt");

      // Randomized programs.
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 16; i++) begin wts[i] = rand_word(); prog[i] = rand_instr(); end
         run_test($sformatf("rand%0d", t));
      end

      // Reset during the third EXEC aborts without writing.
      for (int i = 0; i < 16; i++) begin wts[i] = rand_word(); prog[i] = 16'h0002; end
      load_and_release("abort");
      for (int e = 0; e < 5; e++) @(posedge clk);
      #1;
      check("abort pc_before", 32'(dut.pc), 32'h2);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      model = wts;
      check("abort pc",     32'(dut.pc), 32'h0);
      check("abort state",  32'(dut.state), 32'(S_FETCH));
      check("abort halted", 32'(dut.halted), 32'h0);
      check_weights("abort");
      $display("txn abort: reset during third EXEC, pc=%0d", dut.pc);
      @(negedge clk) rst = 1'b1;
      cyc = 0;
      while (!dut.halted && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("abort rerun cycles", 32'(cyc), 32'd32);
      check("abort rerun pc",     32'(dut.pc), 32'd16);
      check_weights("abort rerun");
      $display("txn abort rerun: cycles=%0d pc=%0d", cyc, dut.pc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
